// File: rtl/fp_mul_ctrl.sv
// fp_mul_ctrl: FP multiplier sequencer (load/step/normalize handshake, sign and exponent with saturation).
// Define FP_MUL_ZERO_BYPASS_EN to short-circuit operands with a zero exponent straight to DONE.
module fp_mul_ctrl #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int BIAS   = 127
) (
    input  logic             clk,
    input  logic             init,
    input  logic             start,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [EXP_W-1:0] b_exp,
    input  logic             msb,
    output logic             mul_load,
    output logic             mul_step,
    output logic             done_mul,
    output logic             out_en,
    output logic             bit47,
    output logic             busy,
    output logic             done,
    output logic             sign_out,
    output logic [EXP_W-1:0] exp_out,
    output logic             ovf,
    output logic             unf
);
    localparam int CW = $clog2(MANT_W + 1);
    localparam logic [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MULT, NORM, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [EXP_W-1:0] a_exp_q, a_exp_d, b_exp_q, b_exp_d;
    logic             a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic             sign_r_q, sign_r_d;
    logic [EXP_W+1:0] exp_sum_q, exp_sum_d, exp_adj;
    logic             sign_out_q, sign_out_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [EXP_W-1:0] exp_out_q, exp_out_d;
    logic             zero_in, take, ovf_c, unf_c;

`ifdef FP_MUL_ZERO_BYPASS_EN
    assign zero_in = (a_exp == '0) || (b_exp == '0);
`else
    assign zero_in = 1'b0;
`endif

    assign take = (state_q == IDLE) && start;

    always_ff @(posedge clk or posedge init) begin
        if (init) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? (zero_in ? DONE : LOAD) : IDLE;
            LOAD:    state_d = MULT;
            MULT:    state_d = (cnt_q == CW'(MANT_W - 1)) ? NORM : MULT;
            NORM:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mul_load = (state_q == LOAD);
        mul_step = (state_q == MULT);
        done_mul = (state_q == NORM);
        out_en   = (state_q == NORM);
        bit47    = (state_q == NORM) && msb;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
    end

    // exp_adj is a 2-bit-wider two's complement value so the sign bit flags underflow
    assign exp_adj = exp_sum_q + {{(EXP_W+1){1'b0}}, msb};
    assign ovf_c   = !exp_adj[EXP_W+1] && (exp_adj >= EMAX);
    assign unf_c   = exp_adj[EXP_W+1] || (exp_adj == '0);

    always_comb begin
        cnt_d      = (state_q == MULT && state_d == MULT) ? cnt_q + 1'b1 : '0;
        a_exp_d    = take ? a_exp : a_exp_q;
        b_exp_d    = take ? b_exp : b_exp_q;
        a_sign_d   = take ? a_sign : a_sign_q;
        b_sign_d   = take ? b_sign : b_sign_q;
        sign_r_d   = (state_q == LOAD) ? a_sign_q ^ b_sign_q : sign_r_q;
        exp_sum_d  = (state_q == LOAD) ? {2'b00, a_exp_q} + {2'b00, b_exp_q} - (EXP_W+2)'(BIAS) : exp_sum_q;
        sign_out_d = sign_out_q;
        exp_out_d  = exp_out_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        if (state_q == NORM) begin
            sign_out_d = sign_r_q;
            exp_out_d  = ovf_c ? '1 : (unf_c ? '0 : exp_adj[EXP_W-1:0]);
            ovf_d      = ovf_c;
            unf_d      = !ovf_c && unf_c;
        end else if (take && zero_in) begin
            sign_out_d = a_sign ^ b_sign;
            exp_out_d  = '0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            cnt_q      <= '0;
            a_exp_q    <= '0;
            b_exp_q    <= '0;
            a_sign_q   <= 1'b0;
            b_sign_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            exp_sum_q  <= '0;
            sign_out_q <= 1'b0;
            exp_out_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            a_exp_q    <= a_exp_d;
            b_exp_q    <= b_exp_d;
            a_sign_q   <= a_sign_d;
            b_sign_q   <= b_sign_d;
            sign_r_q   <= sign_r_d;
            exp_sum_q  <= exp_sum_d;
            sign_out_q <= sign_out_d;
            exp_out_q  <= exp_out_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign sign_out = sign_out_q;
    assign exp_out  = exp_out_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
endmodule

// File: tb/tb_fp_mul_ctrl.sv
// tb_fp_mul_ctrl: scoreboard bench for fp_mul_ctrl; expected results come from plain integer exponent arithmetic.
// Honours FP_MUL_ZERO_BYPASS_EN when modelling zero-exponent operands.
module tb_fp_mul_ctrl;
    logic       clk, init, start, a_sign, b_sign, msb;
    logic [7:0] a_exp, b_exp, exp_out;
    logic       mul_load, mul_step, done_mul, out_en, bit47, busy, done, sign_out, ovf, unf;

    typedef struct {
        logic       s;
        logic [7:0] e;
        logic       o, u, m;
        int         issue, lat;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0, cyc = 0, steps = 0;

    fp_mul_ctrl dut (
        .clk(clk), .init(init), .start(start), .a_sign(a_sign), .b_sign(b_sign),
        .a_exp(a_exp), .b_exp(b_exp), .msb(msb), .mul_load(mul_load), .mul_step(mul_step),
        .done_mul(done_mul), .out_en(out_en), .bit47(bit47), .busy(busy), .done(done),
        .sign_out(sign_out), .exp_out(exp_out), .ovf(ovf), .unf(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, req, cyc);
        end
    endtask

    // Result of an op in plain integer terms: product exponent = ea + eb - bias (+1 if the product carried)
    function automatic exp_t model(input logic as, input logic bs, input int ae, input int be, input logic m, input int issue);
        exp_t r;
        int e;
        e = ae + be - 127 + int'(m);
        r.s = as ^ bs;
        r.o = (e >= 255);
        r.u = (e <= 0);
        r.e = r.o ? 8'd255 : (r.u ? 8'd0 : 8'(e));
        r.m = m;
        r.issue = issue;
        r.lat = 27;
`ifdef FP_MUL_ZERO_BYPASS_EN
        if (ae == 0 || be == 0) begin
            r.e = 8'd0;
            r.o = 1'b0;
            r.u = 1'b0;
            r.lat = 1;
        end
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (!init) begin
            chk("strobe_exclusive", int'(mul_load) + int'(mul_step) + int'(done_mul) <= 1, 1);
            chk("bit47_outside_norm", int'(bit47 & ~done_mul), 0);
            if (mul_load) steps = 0;
            if (mul_step) steps++;
            if (done_mul) begin
                chk("out_en", out_en, 1);
                chk("step_count", steps, 24);
                if (q.size() > 0) chk("bit47", bit47, q[0].m);
            end
            if (done) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    exp_t r;
                    r = q.pop_front();
                    chk("latency", cyc - r.issue, r.lat);
                    chk("sign_out", sign_out, r.s);
                    chk("exp_out", exp_out, r.e);
                    chk("ovf", ovf, r.o);
                    chk("unf", unf, r.u);
                    chk("busy_in_done", busy, 1);
                end
            end
        end
    end

    task automatic issue(input logic as, input logic bs, input logic [7:0] ae, input logic [7:0] be, input logic m);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_timeout", busy, 0);
        a_sign = as;
        b_sign = bs;
        a_exp = ae;
        b_exp = be;
        msb = m;
        start = 1'b1;
        q.push_back(model(as, bs, int'(ae), int'(be), m, cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_during(input int c1, input int c2);
        for (int k = 2; k <= 27; k++) begin
            @(negedge clk);
            start = (k == c1 || k == c2) && busy;
            a_exp = 8'($urandom);
            b_exp = 8'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        init = 1'b1;
        start = 1'b0;
        a_sign = 1'b0;
        b_sign = 1'b0;
        a_exp = '0;
        b_exp = '0;
        msb = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_exp_out", exp_out, 0);
        chk("rst_flags", {sign_out, ovf, unf, done, mul_load, mul_step, done_mul}, 0);
        init = 1'b0;

        issue(1'b0, 1'b0, 8'd127, 8'd127, 1'b0);
        drain();
        issue(1'b0, 1'b1, 8'd127, 8'd127, 1'b1);
        drain();
        issue(1'b0, 1'b0, 8'd254, 8'd254, 1'b0);
        drain();
        issue(1'b1, 1'b1, 8'd1, 8'd1, 1'b0);
        drain();
        issue(1'b0, 1'b1, 8'd0, 8'd130, 1'b0);
        drain();

        issue(1'b1, 1'b0, 8'd100, 8'd90, 1'b1);
        pulse_during(5, 26);
        drain();
        @(negedge clk);
        chk("busy_after_done", busy, 0);

        issue(1'b1, 1'b0, 8'd200, 8'd50, 1'b1);
        repeat (9) @(negedge clk);
        init = 1'b1;
        #1;
        chk("init_mid_busy", busy, 0);
        chk("init_mid_step", mul_step, 0);
        chk("init_mid_result", {sign_out, exp_out, ovf, unf, done}, 0);
        q.delete();
        @(negedge clk);
        init = 1'b0;
        issue(1'b0, 1'b1, 8'd128, 8'd128, 1'b1);
        drain();

        for (int i = 0; i < 20; i++) begin
            issue(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            if (i % 3 == 0) pulse_during(int'($urandom_range(2, 27)), int'($urandom_range(2, 27)));
        end
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
